// File: rtl/mux_rr_stream_pkg.sv
// rtl/mux_rr_stream_pkg.sv - mode constants and channel-index width helper for mux_rr_stream
package mux_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width for n channels; never narrower than one bit
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_stream_if.sv
// rtl/mux_rr_stream_if.sv - producer-side and consumer-side stream bundle of mux_rr_stream
interface mux_rr_stream_if
    import mux_rr_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = sel_width(N)
);

    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/mux_rr_stream_rr_arbiter.sv
// rtl/mux_rr_stream_rr_arbiter.sv - combinational rotating-priority arbiter starting its search at ptr
module rr_arbiter
    import mux_rr_pkg::*;
#(
    parameter int N = 4,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] winner
);

    always_comb begin
        int   idx;
        logic found;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            // ptr is always below N, so a single subtraction is enough to wrap
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (enable && !found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                winner      = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// rtl/mux_rr_stream.sv - N-channel stream mux with fixed or round-robin grant into one output register
module mux_rr_stream
    import mux_rr_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_rr_stream_if.slave bus
);

    localparam int SW = sel_width(N);

    logic [SW-1:0] ptr;
    logic [SW-1:0] winner;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [W-1:0]  win_data;
    logic          load_en;
    logic          sel_ok;
    logic          xfer;

    assign load_en = !bus.out_valid || bus.out_ready;
    assign sel_ok  = int'(bus.sel) < N;

    // Fixed mode narrows the request vector to the selected channel so the same arbiter serves both modes
    always_comb begin
        req = '0;
        if (bus.mode == MODE_RR) begin
            req = bus.in_valid;
        end else if (sel_ok) begin
            req[bus.sel] = bus.in_valid[bus.sel];
        end
    end

    rr_arbiter #(.N(N)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .enable (load_en && rst_n),
        .grant  (grant),
        .winner (winner)
    );

    assign bus.in_ready = grant;
    assign xfer         = |grant;
    assign win_data     = bus.in_data[winner*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            bus.out_valid <= 1'b0;
            ptr           <= '0;
        end else if (xfer) begin
            bus.out_data  <= win_data;
            bus.out_chan  <= winner;
            bus.out_valid <= 1'b1;
            if (bus.mode == MODE_RR) begin
                ptr <= (int'(winner) == N - 1) ? '0 : winner + SW'(1);
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_stream.sv
// tb/tb_mux_rr_stream.sv - directed self-checking bench for mux_rr_stream
module tb_mux_rr_stream;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_rr_stream_if #(.N(4), .W(8)) bus ();

    mux_rr_stream #(.N(4), .W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] exp_data [4];
        exp_data[0] = 8'h11;
        exp_data[1] = 8'h22;
        exp_data[2] = 8'hA5;
        exp_data[3] = 8'h33;
        checks = 0;
        errors = 0;

        rst_n         = 1'b0;
        bus.in_data   = {8'h33, 8'hA5, 8'h22, 8'h11};
        bus.in_valid  = 4'b1111;
        bus.mode      = 1'b1;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b1;

        // Reset with every channel requesting
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        chk("rst_out_chan",  32'(bus.out_chan),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd0);

        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        chk("rr_first_valid", 32'(bus.out_valid), 32'd1);
        chk("rr_first_chan",  32'(bus.out_chan),  32'd0);
        chk("rr_first_data",  32'(bus.out_data),  32'h11);

        // Fairness: channels 1,2,3,0,1,2,3 follow, one per cycle
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("rr_seq_chan",  32'(bus.out_chan),  32'(k % 4));
            chk("rr_seq_data",  32'(bus.out_data),  32'(exp_data[k % 4]));
            chk("rr_seq_valid", 32'(bus.out_valid), 32'd1);
        end

        // Fixed select of channel 2
        bus.mode = 1'b0;
        bus.sel  = 2'd2;
        #1;
        chk("fix_ready_sel2", 32'(bus.in_ready), 32'b0100);
        tick();
        chk("fix_data_sel2", 32'(bus.out_data), 32'hA5);
        chk("fix_chan_sel2", 32'(bus.out_chan), 32'd2);

        // Selected channel idle: no grant, register drains and holds its word
        bus.sel      = 2'd3;
        bus.in_valid = 4'b0111;
        #1;
        chk("fix_ready_sel3", 32'(bus.in_ready), 32'd0);
        tick();
        chk("fix_drain_valid", 32'(bus.out_valid), 32'd0);
        chk("fix_hold_data",   32'(bus.out_data),  32'hA5);
        chk("fix_hold_chan",   32'(bus.out_chan),  32'd2);

        // Sparse requests; ptr stayed 0 through fixed mode so ch1 wins first
        bus.mode     = 1'b1;
        bus.in_valid = 4'b1010;
        #1;
        chk("sp_ready0", 32'(bus.in_ready), 32'b0010);
        tick();
        chk("sp_chan0", 32'(bus.out_chan), 32'd1);
        #1;
        chk("sp_ready1", 32'(bus.in_ready), 32'b1000);
        tick();
        chk("sp_chan1", 32'(bus.out_chan), 32'd3);
        chk("sp_data1", 32'(bus.out_data), 32'h33);
        #1;
        chk("sp_ready2", 32'(bus.in_ready), 32'b0010);
        tick();
        chk("sp_chan2", 32'(bus.out_chan), 32'd1);
        tick();
        chk("sp_chan3", 32'(bus.out_chan), 32'd3);

        // Backpressure with a full register
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'b1111;
        #1;
        chk("bp_ready_pre", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_data",  32'(bus.out_data),  32'h33);
            chk("bp_chan",  32'(bus.out_chan),  32'd3);
            chk("bp_ready", 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0001;
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        chk("bp_reload_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_reload_data",  32'(bus.out_data),  32'h11);
        chk("bp_reload_chan",  32'(bus.out_chan),  32'd0);

        // Advance ptr to 2 via a ch1 transfer
        bus.in_valid = 4'b0010;
        tick();
        chk("ms_pre_chan", 32'(bus.out_chan), 32'd1);

        // Switch to fixed sel=1 while the word is held
        bus.out_ready      = 1'b0;
        bus.mode           = 1'b0;
        bus.sel            = 2'd1;
        bus.in_valid       = 4'b1111;
        bus.in_data[15:8]  = 8'h5A;
        #1;
        chk("ms_hold_ready", 32'(bus.in_ready), 32'd0);
        tick();
        chk("ms_hold_data", 32'(bus.out_data), 32'h22);
        chk("ms_hold_chan", 32'(bus.out_chan), 32'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("ms_fix_ready", 32'(bus.in_ready), 32'b0010);
        tick();
        chk("ms_fix_data", 32'(bus.out_data), 32'h5A);
        chk("ms_fix_chan", 32'(bus.out_chan), 32'd1);

        // Back to round-robin: search resumes at ptr=2
        bus.mode = 1'b1;
        #1;
        chk("ms_rr_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        chk("ms_rr_chan", 32'(bus.out_chan), 32'd2);
        chk("ms_rr_data", 32'(bus.out_data), 32'hA5);

        // Reset while holding a word discards it and returns ptr to 0
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        chk("post_rst_chan", 32'(bus.out_chan), 32'd0);
        chk("post_rst_data", 32'(bus.out_data), 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
